dflipflop_bank: RTL and testbench

DFLIPFLOP_BANK -- requirements
Module: dflipflop_bank

---
 rtl/dflipflop_bank.sv | 113 +++++++++++
 tb/tb_dflipflop_bank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dflipflop_bank.sv
// Bank of DEPTH data stages, each paired with a valid bit, supporting hold, serial shift,
// parallel load and rotate. Stage data is registered; occupancy (fill/full) decodes directly from the valid bits.
module dflipflop_bank #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clr,
    input  logic                               en,
    input  logic [1:0]                         mode,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               din_vld,
    input  logic [WIDTH*DEPTH-1:0]             pdin,
    output logic [WIDTH-1:0]                   dout,
    output logic                               vout,
    output logic [WIDTH*DEPTH-1:0]             pdout,
    output logic [$clog2(DEPTH+1)-1:0]         fill,
    output logic                               full
);

    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    // Number of set bits in a valid vector.
    function automatic logic [FW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [FW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + FW'(v[i]);
        end
        return cnt;
    endfunction

    // Packed so that stage i maps onto bits [i*WIDTH +: WIDTH] of pdout.
    logic [DEPTH-1:0][WIDTH-1:0] stage_r;
    logic [DEPTH-1:0][WIDTH-1:0] stage_nxt_s;
    logic [DEPTH-1:0]            valid_r;
    logic [DEPTH-1:0]            valid_nxt_s;
    mode_e                       mode_s;

    assign mode_s = mode_e'(mode);

    // Next-state selection: clear wins over enable, enable gates the mode.
    always_comb begin
        stage_nxt_s = stage_r;
        valid_nxt_s = valid_r;
        if (clr) begin
            stage_nxt_s = {DEPTH{RESET_VAL}};
            valid_nxt_s = '0;
        end else if (en) begin
            case (mode_s)
                MODE_HOLD: begin
                    stage_nxt_s = stage_r;
                    valid_nxt_s = valid_r;
                end
                MODE_SHIFT: begin
                    stage_nxt_s[0] = din;
                    valid_nxt_s[0] = din_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_nxt_s[i] = stage_r[i-1];
                        valid_nxt_s[i] = valid_r[i-1];
                    end
                end
                MODE_LOAD: begin
                    stage_nxt_s = pdin;
                    valid_nxt_s = '1;
                end
                MODE_ROTATE: begin
                    // With DEPTH=1 the last stage is stage 0, so this degenerates to hold.
                    stage_nxt_s[0] = stage_r[DEPTH-1];
                    valid_nxt_s[0] = valid_r[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_nxt_s[i] = stage_r[i-1];
                        valid_nxt_s[i] = valid_r[i-1];
                    end
                end
                default: begin
                    stage_nxt_s = stage_r;
                    valid_nxt_s = valid_r;
                end
            endcase
        end else begin
            stage_nxt_s = stage_r;
            valid_nxt_s = valid_r;
        end
    end

    // Stage and valid registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r <= {DEPTH{RESET_VAL}};
            valid_r <= '0;
        end else begin
            stage_r <= stage_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign dout  = stage_r[DEPTH-1];
    assign vout  = valid_r[DEPTH-1];
    assign pdout = stage_r;
    assign fill  = popcount(valid_r);
    assign full  = (fill == FW'(DEPTH));

endmodule

// File: tb/tb_dflipflop_bank.sv
// Randomized scoreboard bench for dflipflop_bank: a DEPTH=4 and a DEPTH=1 instance share stimulus,
// a queue-based reference model predicts each edge, and a negedge monitor compares.
module tb_dflipflop_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  din;
    logic        din_vld;
    logic [31:0] pdin;

    logic [7:0]  dout;
    logic        vout;
    logic [31:0] pdout;
    logic [2:0]  fill;
    logic        full;

    logic [7:0]  dout1;
    logic        vout1;
    logic [7:0]  pdout1;
    logic [0:0]  fill1;
    logic        full1;

    int total = 0;
    int bad   = 0;

    dflipflop_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode),
        .din(din), .din_vld(din_vld), .pdin(pdin),
        .dout(dout), .vout(vout), .pdout(pdout), .fill(fill), .full(full)
    );

    dflipflop_bank #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode),
        .din(din), .din_vld(din_vld), .pdin(pdin[7:0]),
        .dout(dout1), .vout(vout1), .pdout(pdout1), .fill(fill1), .full(full1)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 of each queue is stage 0.
    logic [7:0] m_data[$];
    logic       m_vld[$];
    logic [7:0] m1_data;
    logic       m1_vld;

    typedef struct {
        logic [31:0] pd;
        logic [7:0]  d;
        logic        v;
        int          f;
        logic        fu;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t snap4();
        exp_t e;
        e.pd = '0;
        e.f  = 0;
        for (int i = 0; i < 4; i++) begin
            e.pd[i*8 +: 8] = m_data[i];
            if (m_vld[i]) e.f++;
        end
        e.d  = m_data[3];
        e.v  = m_vld[3];
        e.fu = (e.f == 4);
        return e;
    endfunction

    function automatic exp_t snap1();
        exp_t e;
        e.pd = {24'h000000, m1_data};
        e.d  = m1_data;
        e.v  = m1_vld;
        e.f  = m1_vld ? 1 : 0;
        e.fu = m1_vld;
        return e;
    endfunction

    task automatic model_clear();
        m_data = {8'h00, 8'h00, 8'h00, 8'h00};
        m_vld  = {1'b0, 1'b0, 1'b0, 1'b0};
        m1_data = 8'h00;
        m1_vld  = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic e, input logic [1:0] m,
                              input logic [7:0] di, input logic dv, input logic [31:0] pd);
        logic [7:0] td;
        logic       tv;
        if (c) begin
            model_clear();
        end else if (e) begin
            case (m)
                2'b01: begin
                    m_data.push_front(di); void'(m_data.pop_back());
                    m_vld.push_front(dv);  void'(m_vld.pop_back());
                    m1_data = di;
                    m1_vld  = dv;
                end
                2'b10: begin
                    for (int i = 0; i < 4; i++) begin
                        m_data[i] = pd[i*8 +: 8];
                        m_vld[i]  = 1'b1;
                    end
                    m1_data = pd[7:0];
                    m1_vld  = 1'b1;
                end
                2'b11: begin
                    td = m_data.pop_back(); m_data.push_front(td);
                    tv = m_vld.pop_back();  m_vld.push_front(tv);
                end
                default: ;
            endcase
        end
    endtask

    // One clock edge of stimulus; control is parked idle afterwards so unmodelled edges are holds.
    task automatic do_cycle(input logic c, input logic e, input logic [1:0] m,
                            input logic [7:0] di, input logic dv, input logic [31:0] pd);
        @(negedge clk);
        #1;
        clr = c; en = e; mode = m; din = di; din_vld = dv; pdin = pd;
        @(posedge clk);
        model_step(c, e, m, di, dv, pd);
        q4.push_back(snap4());
        q1.push_back(snap1());
        #1;
        clr = 1'b0;
        en  = 1'b0;
    endtask

    // Asynchronous reset pulse landing mid-cycle, checked before the next rising edge.
    task automatic do_reset(input logic chk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        q4.push_back(snap4());
        q1.push_back(snap1());
        #1;
        if (chk) begin
            cmp("rst_dout", {56'd0, dout}, 64'h00);
            cmp("rst_fill", {61'd0, fill}, 64'd0);
            cmp("rst_full", {63'd0, full}, 64'd0);
            cmp("rst_vout", {63'd0, vout}, 64'd0);
            cmp("rst_pdout", {32'd0, pdout}, 64'h0);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    exp_t e4;
    exp_t e1;

    // Monitor: whenever an expectation is pending, compare the settled outputs mid-cycle.
    always @(negedge clk) begin
        if (q4.size() != 0) begin
            e4 = q4.pop_front();
            cmp("d4_pdout", {32'd0, pdout}, {32'd0, e4.pd});
            cmp("d4_dout",  {56'd0, dout},  {56'd0, e4.d});
            cmp("d4_vout",  {63'd0, vout},  {63'd0, e4.v});
            cmp("d4_fill",  {61'd0, fill},  64'(e4.f));
            cmp("d4_full",  {63'd0, full},  {63'd0, e4.fu});
        end
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            cmp("d1_pdout", {56'd0, pdout1}, {56'd0, e1.pd[7:0]});
            cmp("d1_dout",  {56'd0, dout1},  {56'd0, e1.d});
            cmp("d1_vout",  {63'd0, vout1},  {63'd0, e1.v});
            cmp("d1_fill",  {63'd0, fill1},  64'(e1.f));
            cmp("d1_full",  {63'd0, full1},  {63'd0, e1.fu});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00;
        din = 8'h00; din_vld = 1'b0; pdin = 32'h0;
        model_clear();
        #12;
        cmp("init_dout", {56'd0, dout}, 64'h00);
        cmp("init_fill", {61'd0, fill}, 64'd0);
        cmp("init_full", {63'd0, full}, 64'd0);
        cmp("init_vout", {63'd0, vout}, 64'd0);
        reset = 1'b1;

        // LOAD then asynchronous reset mid-cycle.
        do_cycle(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'hCAFE_F00D);
        cmp("load_full", {63'd0, full}, 64'd1);
        do_reset(1'b1);

        // Serial fill: four shifts, first word reaches dout on the fourth edge.
        do_cycle(1'b0, 1'b1, 2'b01, 8'h11, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h22, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h33, 1'b1, 32'h0);
        cmp("shift3_dout", {56'd0, dout}, 64'h00);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h44, 1'b1, 32'h0);
        cmp("shift_dout",  {56'd0, dout}, 64'h11);
        cmp("shift_full",  {63'd0, full}, 64'd1);
        cmp("shift_fill",  {61'd0, fill}, 64'd4);
        cmp("shift_pdout", {32'd0, pdout}, 64'h1122_3344);

        // Rotate a loaded pattern all the way round.
        do_cycle(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'h4433_2211);
        for (int r = 0; r < 4; r++) begin
            do_cycle(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 32'h0);
            cmp("rot_fill", {61'd0, fill}, 64'd4);
        end
        cmp("rot_pdout", {32'd0, pdout}, 64'h4433_2211);

        // Clear beats enable+LOAD; disabled SHIFT changes nothing.
        do_cycle(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 32'hFFFF_FFFF);
        cmp("clr_pdout", {32'd0, pdout}, 64'h0);
        cmp("clr_fill",  {61'd0, fill}, 64'd0);
        do_cycle(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'hDEAD_BEEF);
        do_cycle(1'b0, 1'b0, 2'b01, 8'h5A, 1'b1, 32'h0);
        cmp("en0_pdout", {32'd0, pdout}, 64'hDEAD_BEEF);
        cmp("en0_fill",  {61'd0, fill}, 64'd4);

        // Full bank, shift in an invalid word: fill drops by one.
        do_cycle(1'b0, 1'b1, 2'b01, 8'h77, 1'b0, 32'h0);
        cmp("drop_fill", {61'd0, fill}, 64'd3);

        // Valid gaps: oldest-first 0,1,0,1 lands as valid[3:0]=0101.
        do_cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h01, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h02, 1'b1, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h03, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'h04, 1'b1, 32'h0);
        cmp("gap_fill",  {61'd0, fill}, 64'd2);
        cmp("gap_valid", {60'd0, u_dut.valid_r}, 64'h5);
        cmp("gap_full",  {63'd0, full}, 64'd0);

        // Single-stage instance: one-edge shift, rotate holds.
        do_cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 2'b01, 8'hA5, 1'b1, 32'h0);
        cmp("d1_shift_dout", {56'd0, dout1}, 64'hA5);
        do_cycle(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 32'h0);
        cmp("d1_rot_dout",  {56'd0, dout1}, 64'hA5);
        cmp("d1_rot_full",  {63'd0, full1}, 64'd1);

        // Randomized traffic with occasional clears and async resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1'b0);
            end else begin
                do_cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                         2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), $urandom);
            end
        end

        for (int w = 0; w < 10 && (q4.size() != 0 || q1.size() != 0); w++) begin
            @(posedge clk);
        end
        if (q4.size() != 0 || q1.size() != 0) begin
            cmp("drain", 64'(q4.size() + q1.size()), 64'd0);
        end
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
